// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester port indices and default bus widths.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic PORT_CORE  = 1'b0;  // load/store unit
  localparam logic PORT_LOAD  = 1'b1;  // program/debug loader
  localparam int   NUM_PORTS  = 2;
  localparam int   DATA_W_DEF = 32;
  localparam int   ADDR_W_DEF = 32;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational winner select for the two requesters.
// Round-robin on a tie by default; with DMEM_ARB_FIXED_PRIO_EN defined the
// core port always wins a tie and last_grant is ignored.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant
);

  // Single requester gets the grant; on a tie the port that did not win last.
  always_comb begin
    grant = PORT_CORE;
    if (req0 && req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      grant = PORT_CORE;
`else
      grant = ~last_grant;
`endif
    end else if (req1) begin
      grant = PORT_LOAD;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port 256-word data memory.
// Each transaction is IDLE -> ACCESS -> RESP: operands of the winner are
// latched onto the memory bus for one ACCESS cycle, read data is captured at
// the end of it, and the requester sees a one-cycle ack during RESP.
// Optional: DMEM_ARB_FIXED_PRIO_EN makes port 0 win every tie.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              busy
);

  // Per-port request bundles gathered into packed arrays so the winner's
  // operands can be selected by index.
  logic [NUM_PORTS-1:0]             req_v;
  logic [NUM_PORTS-1:0]             we_v;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_v;

  assign req_v   = {req1, req0};
  assign we_v    = {we1, we0};
  assign addr_v  = {addr1, addr0};
  assign wdata_v = {wdata1, wdata0};

  state_e                           state_q, state_d;
  logic                             sel_q, sel_d;
  logic                             last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]                mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]                mem_wd_q, mem_wd_d;
  logic                             mem_we_q, mem_we_d;
  logic [NUM_PORTS-1:0]             ack_q, ack_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic                             win;

  dmem_rr_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .grant      (win)
  );

  // State and datapath registers; reset drops any in-flight access.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      sel_q        <= PORT_CORE;
      last_grant_q <= PORT_LOAD;   // so port 0 wins the first tie
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
      mem_we_q     <= 1'b0;
      ack_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wd_q     <= mem_wd_d;
      mem_we_q     <= mem_we_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next state: every accepted request walks the fixed three-cycle sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (|req_v) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: latch winner in IDLE, capture read data and raise
  // ack leaving ACCESS; ack is cleared again leaving RESP.
  always_comb begin
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wd_d     = mem_wd_q;
    mem_we_d     = mem_we_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_v) begin
          sel_d        = win;
          last_grant_d = win;
          mem_addr_d   = addr_v[win];
          mem_wd_d     = wdata_v[win];
          mem_we_d     = we_v[win];
        end
      end
      ST_ACCESS: begin
        // Writes leave the requester's last read word untouched.
        if (!mem_we_q) rdata_d[sel_q] = mem_rd;
        mem_we_d     = 1'b0;
        ack_d[sel_q] = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs straight from registers; busy covers ACCESS and RESP.
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;
  assign mem_we   = mem_we_q;
  assign ack0     = ack_q[PORT_CORE];
  assign ack1     = ack_q[PORT_LOAD];
  assign rdata0   = rdata_q[PORT_CORE];
  assign rdata1   = rdata_q[PORT_LOAD];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory
// (combinational read, posedge write, 256 words).
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, mem_we, busy;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [256];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always #5 CLK = ~CLK;

  assign mem_rd = ram[mem_addr[7:0]];

  always @(posedge CLK) begin
    if (mem_we)     ram[mem_addr[7:0]] <= mem_wd;
    else if (pl_we) ram[pl_addr]       <= pl_data;
  end

  dmem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_rd(mem_rd), .busy(busy)
  );

  // Backdoor memory preload through the model's own write port.
  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge CLK);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge CLK);
    pl_we = 1'b0;
  endtask

  // One single-port transaction started in IDLE; reports negedges until ack
  // (-1 if none within the bound), mem_we cycles seen and any ack on the
  // other port. Returns one cycle after ack, i.e. back in IDLE.
  task automatic run_one(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output int cyc, output int wec,
                         output logic oth);
    logic done;
    cyc = -1; wec = 0; oth = 1'b0; done = 1'b0;
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    for (int i = 1; i <= 20 && !done; i++) begin
      @(negedge CLK);
      if (mem_we) wec++;
      if ((p == 0) ? ack1 : ack0) oth = 1'b1;
      if ((p == 0) ? ack0 : ack1) begin
        cyc = i; done = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({ack0, ack1, mem_we, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {ack0, ack1, mem_we, busy});
    end
    checks++;
    if ({rdata0, rdata1, mem_addr, mem_wd} !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h exp all 0", rdata0, rdata1, mem_addr, mem_wd);
    end
    // Reset arrives while a write is on the memory bus.
    preload(8'd5, 32'h55);
    RST = 1'b1;
    @(negedge CLK);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd5; wdata0 = 32'hAA;
    @(negedge CLK);
    checks++;
    if ({mem_we, busy} !== 2'b11) begin
      errors++; $display("FAIL midreset_access got we/busy %b exp 11", {mem_we, busy});
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({ack0, ack1, mem_we, busy} !== 4'b0000 || mem_addr !== 32'h0 || mem_wd !== 32'h0) begin
      errors++; $display("FAIL midreset_outs got %b %h %h exp 0", {ack0, ack1, mem_we, busy}, mem_addr, mem_wd);
    end
    req0 = 1'b0; we0 = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (ram[5] !== 32'h55 || ack0 !== 1'b0) begin
      errors++; $display("FAIL midreset_nowrite got ram5=%h ack0=%b exp 55 0", ram[5], ack0);
    end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_write_read();
    int cyc, wec;
    logic oth;
    run_one(0, 1'b1, 32'h10, 32'hDEADBEEF, cyc, wec, oth);
    checks++;
    if (cyc !== 2 || wec !== 1 || oth !== 1'b0) begin
      errors++; $display("FAIL wr_timing got lat=%0d we_cycles=%0d ack1=%b exp 2 1 0", cyc, wec, oth);
    end
    checks++;
    if (ram[16] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_mem got %h exp deadbeef", ram[16]);
    end
    run_one(0, 1'b0, 32'h10, 32'h0, cyc, wec, oth);
    checks++;
    if (cyc !== 2 || wec !== 0 || oth !== 1'b0) begin
      errors++; $display("FAIL rd_timing got lat=%0d we_cycles=%0d ack1=%b exp 2 0 0", cyc, wec, oth);
    end
    checks++;
    if (rdata0 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_data got %h exp deadbeef", rdata0);
    end
  endtask

  task automatic test_tie();
    int c0, c1;
    preload(8'd3, 32'h11);
    preload(8'd4, 32'h22);
    RST = 1'b0; @(negedge CLK); RST = 1'b1; @(negedge CLK);
    c0 = -1; c1 = -1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (ack0 && c0 < 0) begin c0 = i; req0 = 1'b0; end
      if (ack1 && c1 < 0) begin c1 = i; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (c0 !== 2 || c1 !== 5) begin
      errors++; $display("FAIL tie_order got ack0@%0d ack1@%0d exp 2 5", c0, c1);
    end
    checks++;
    if (rdata0 !== 32'h11 || rdata1 !== 32'h22) begin
      errors++; $display("FAIL tie_data got %h %h exp 11 22", rdata0, rdata1);
    end
  endtask

  task automatic test_back_to_back();
    int g[4];
    int t[4];
    int exp_g[4];
    int n;
    logic prev_ack;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    n = 0; prev_ack = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
    for (int i = 1; i <= 40 && n < 4; i++) begin
      @(negedge CLK);
      if (prev_ack) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL b2b_idle_gap got busy=%b exp 0 at cycle %0d", busy, i);
        end
      end
      prev_ack = ack0 | ack1;
      if (ack0 | ack1) begin
        g[n] = ack1 ? 1 : 0;
        t[n] = i;
        n++;
        if (n == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge CLK);
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL b2b_count got %0d acks exp 4", n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (g[k] !== exp_g[k]) begin
          errors++; $display("FAIL b2b_grant%0d got %0d exp %0d", k, g[k], exp_g[k]);
        end
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (t[k] - t[k-1] !== 3) begin
          errors++; $display("FAIL b2b_spacing%0d got %0d exp 3", k, t[k] - t[k-1]);
        end
      end
    end
  endtask

  task automatic test_raw();
    int cyc, wec, c0, c1;
    logic oth;
    logic [31:0] exp_r0;
    int exp_c0, exp_c1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_r0 = 32'h1; exp_c0 = 2; exp_c1 = 5;
`else
    exp_r0 = 32'h9; exp_c0 = 5; exp_c1 = 2;
`endif
    preload(8'd7, 32'h1);
    // Solo port-0 access leaves last_grant = 0, so round-robin favours port 1.
    run_one(0, 1'b0, 32'd0, 32'h0, cyc, wec, oth);
    checks++;
    if (cyc !== 2) begin
      errors++; $display("FAIL raw_prime got lat=%0d exp 2", cyc);
    end
    c0 = -1; c1 = -1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd7;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd7; wdata1 = 32'h9;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (ack0 && c0 < 0) begin c0 = i; req0 = 1'b0; end
      if (ack1 && c1 < 0) begin c1 = i; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
    checks++;
    if (c0 !== exp_c0 || c1 !== exp_c1) begin
      errors++; $display("FAIL raw_order got ack0@%0d ack1@%0d exp %0d %0d", c0, c1, exp_c0, exp_c1);
    end
    checks++;
    if (rdata0 !== exp_r0 || ram[7] !== 32'h9) begin
      errors++; $display("FAIL raw_data got rdata0=%h ram7=%h exp %h 9", rdata0, ram[7], exp_r0);
    end
    checks++;
    if (rdata1 !== 32'h22) begin
      errors++; $display("FAIL raw_wr_keeps_rdata1 got %h exp 22", rdata1);
    end
    run_one(0, 1'b0, 32'd7, 32'h0, cyc, wec, oth);
    checks++;
    if (rdata0 !== 32'h9) begin
      errors++; $display("FAIL raw_readback got %h exp 9", rdata0);
    end
  endtask

  task automatic test_held_req();
    int c[2];
    int n;
    n = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3;
    for (int i = 1; i <= 20 && n < 2; i++) begin
      @(negedge CLK);
      if (ack0) begin
        c[n] = i; n++;
        if (n == 2) req0 = 1'b0;
      end
    end
    req0 = 1'b0;
    @(negedge CLK);
    checks++;
    if (n !== 2) begin
      errors++; $display("FAIL held_count got %0d acks exp 2", n);
    end else begin
      checks++;
      if (c[0] !== 2 || c[1] !== 5) begin
        errors++; $display("FAIL held_timing got %0d %0d exp 2 5", c[0], c[1]);
      end
    end
    checks++;
    if (busy !== 1'b0 || ack0 !== 1'b0) begin
      errors++; $display("FAIL held_idle got busy=%b ack0=%b exp 0 0", busy, ack0);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_back_to_back();
    test_raw();
    test_held_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
